octa16_dmem_arbiter: RTL and testbench

Two-master arbiter and boot sequencer for the Octa16 data memory. It shares the single-port data memory between the external loader port (`Ext_*` path, used to preload program data) and the core load/store unit. It holds the core off until the loader declares the image complete, then alternates fairly between both masters.

---
 rtl/octa16_dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_octa16_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/octa16_dmem_arbiter.sv
// Octa16 data memory arbiter: shares the single-port data memory between the
// external loader and the core load/store unit. The core is held off (BOOT)
// until the loader signals the image is complete; afterwards both masters are
// served round-robin on contention.
module octa16_dmem_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,       // asynchronous, active-low

  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,

  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,

  input  logic          boot_done,
  output logic          core_stall,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic StBoot = 1'b0;
  localparam logic StRun  = 1'b1;

  // Last-winner pointer encoding.
  localparam logic PtrExt  = 1'b0;
  localparam logic PtrCore = 1'b1;

  logic state_q, state_d;
  logic last_q, last_d;
  logic rvalid_q, rvalid_d;
  logic owner_q, owner_d;  // 1 = core owns the pending read return

  // Grant decision: ext only in BOOT, round-robin on a tie in RUN.
  always_comb begin
    ext_gnt  = 1'b0;
    core_gnt = 1'b0;
    if (state_q == StBoot) begin
      ext_gnt = ext_req;
    end else if (ext_req && core_req) begin
      if (last_q == PtrExt) begin
        core_gnt = 1'b1;
      end else begin
        ext_gnt = 1'b1;
      end
    end else begin
      ext_gnt  = ext_req;
      core_gnt = core_req;
    end
  end

  // Memory port mux; all fields forced to zero when nothing is granted.
  always_comb begin
    mem_en    = ext_gnt | core_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // Next-state: boot release, pointer update on grant, read-return tagging.
  always_comb begin
    state_d = state_q;
    if (state_q == StBoot && boot_done) begin
      state_d = StRun;
    end

    last_d = last_q;
    if (core_gnt) begin
      last_d = PtrCore;
    end else if (ext_gnt) begin
      last_d = PtrExt;
    end

    rvalid_d = mem_en & ~mem_we;
    owner_d  = core_gnt;
  end

  // State registers; reset discards any pending read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StBoot;
      last_q   <= PtrExt;
      rvalid_q <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  // Read return steering: only the owner sees valid data, the other sees zero.
  always_comb begin
    core_stall  = (state_q == StBoot);
    ext_rvalid  = rvalid_q & ~owner_q;
    core_rvalid = rvalid_q & owner_q;
    ext_rdata   = ext_rvalid  ? mem_rdata : '0;
    core_rdata  = core_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_octa16_dmem_arbiter.sv
// Bench for octa16_dmem_arbiter: directed stimulus with a scoreboard queue per
// master for read returns, checked by an independent monitor.
module tb_octa16_dmem_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          boot_done = 1'b0;
  logic          core_stall;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [16];

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] ext_q[$];
  logic [DW-1:0] core_q[$];

  octa16_dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .boot_done  (boot_done),
    .core_stall (core_stall),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: pops the expected read data whenever a master sees rvalid.
  always @(negedge clk) begin
    if (ext_rvalid) begin
      if (ext_q.size() == 0) chk("ext_rvalid_unexpected", 1, 0);
      else chk("ext_rdata", {16'h0, ext_rdata}, {16'h0, ext_q.pop_front()});
      chk("core_rdata_nonowner", {16'h0, core_rdata}, 0);
    end
    if (core_rvalid) begin
      if (core_q.size() == 0) chk("core_rvalid_unexpected", 1, 0);
      else chk("core_rdata", {16'h0, core_rdata}, {16'h0, core_q.pop_front()});
      chk("ext_rdata_nonowner", {16'h0, ext_rdata}, 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  logic [DW-1:0] boot_vals [4];

  initial begin
    boot_vals[0] = 16'hABCD;
    boot_vals[1] = 16'h1234;
    boot_vals[2] = 16'h5678;
    boot_vals[3] = 16'h9ABC;

    // Reset values.
    #2;
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_rvalid", {ext_rvalid, core_rvalid}, 0);
    chk("rst_rdata", {ext_rdata, core_rdata}, 0);
    chk("rst_core_stall", core_stall, 1);
    chk("rst_mem_en_we", {mem_en, mem_we}, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // Boot load with the core also requesting.
    for (int i = 0; i < 4; i++) begin
      ext_req = 1; ext_we = 1; ext_addr = AW'(i); ext_wdata = boot_vals[i];
      core_req = 1; core_we = 0; core_addr = 0;
      mid();
      chk("boot_ext_gnt", ext_gnt, 1);
      chk("boot_core_gnt", core_gnt, 0);
      chk("boot_core_stall", core_stall, 1);
      cyc();
    end
    ext_req = 0; core_req = 0;
    for (int i = 0; i < 4; i++) chk("boot_mem", {16'h0, mem[i]}, {16'h0, boot_vals[i]});

    // Boot release.
    boot_done = 1;
    mid();
    chk("release_stall_same_cycle", core_stall, 1);
    cyc();
    boot_done = 0;
    core_req = 1; core_we = 0; core_addr = 2;
    core_q.push_back(16'h5678);
    mid();
    chk("release_stall_next", core_stall, 0);
    chk("release_core_gnt", core_gnt, 1);
    chk("release_mem_addr", mem_addr, 2);
    cyc();
    core_req = 0;

    // Lone ext read moves the pointer to ext so the core wins the next tie.
    ext_req = 1; ext_we = 0; ext_addr = 0;
    ext_q.push_back(16'hABCD);
    mid();
    chk("lone_ext_gnt", ext_gnt, 1);
    cyc();

    // Round-robin: both hold reads for four cycles.
    core_req = 1; core_we = 0; core_addr = 1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) core_q.push_back(16'h1234);
      else            ext_q.push_back(16'hABCD);
      mid();
      chk("rr_core_gnt", core_gnt, (k % 2 == 0) ? 1 : 0);
      chk("rr_ext_gnt", ext_gnt, (k % 2 == 0) ? 0 : 1);
      cyc();
    end
    ext_req = 0; core_req = 0;

    // Write by core then read by ext of the same address.
    core_req = 1; core_we = 1; core_addr = 3; core_wdata = 16'h0F0F;
    mid();
    chk("wr_core_gnt", core_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    cyc();
    core_req = 0; core_we = 0;
    ext_req = 1; ext_we = 0; ext_addr = 3;
    ext_q.push_back(16'h0F0F);
    mid();
    chk("rd_ext_gnt", ext_gnt, 1);
    cyc();
    ext_req = 0;

    // Idle, plus boot_done ignored in RUN.
    cyc();
    boot_done = 1;
    mid();
    chk("idle_mem_en", mem_en, 0);
    chk("idle_gnt", {ext_gnt, core_gnt}, 0);
    chk("idle_rvalid", {ext_rvalid, core_rvalid}, 0);
    chk("idle_mem_fields", {mem_we, mem_addr, mem_wdata}, 0);
    cyc();
    boot_done = 0;
    chk("run_boot_done_ignored", core_stall, 0);

    // Reset in the cycle after a granted core read.
    core_req = 1; core_we = 0; core_addr = 1;
    mid();
    chk("mid_core_gnt", core_gnt, 1);
    cyc();
    core_req = 0;
    chk("mid_rvalid_before_reset", core_rvalid, 1);
    reset = 0;
    #1;
    chk("mid_rvalid_dropped", core_rvalid, 0);
    chk("mid_stall", core_stall, 1);
    cyc();
    reset = 1;
    core_req = 1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("post_rst_core_gnt", core_gnt, 0);
      chk("post_rst_mem_en", mem_en, 0);
      cyc();
    end

    // boot_done coincident with an ext write: ext granted now, core next cycle.
    ext_req = 1; ext_we = 1; ext_addr = 5; ext_wdata = 16'h5555;
    boot_done = 1;
    mid();
    chk("coincident_ext_gnt", ext_gnt, 1);
    chk("coincident_core_gnt", core_gnt, 0);
    cyc();
    ext_req = 0; boot_done = 0;
    core_q.push_back(16'h1234);
    mid();
    chk("after_boot_core_gnt", core_gnt, 1);
    chk("after_boot_stall", core_stall, 0);
    cyc();
    core_req = 0;
    cyc();
    cyc();
    chk("ext_q_drained", ext_q.size(), 0);
    chk("core_q_drained", core_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
